// File: rtl/pc_cc_fifo.sv
// rtl/pc_cc_fifo.sv - circular (pc, cc_id) thread FIFO with per-slot occupancy tracking
// in_ready never looks at out_ready, so the CPU -> FIFO -> CPU loop has no combinational path.
module pc_cc_fifo #(
  parameter int PC_WIDTH              = 9,
  parameter int CC_ID_BITS            = 2,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [PC_WIDTH-1:0]              in_pc,
  input  logic [CC_ID_BITS-1:0]            in_cc_id,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [PC_WIDTH-1:0]              out_pc,
  output logic [CC_ID_BITS-1:0]            out_cc_id,
  input  logic                             out_ready,
  output logic [FIFO_WIDTH_POWER_OF_2:0]   occupancy,
  output logic [(2**CC_ID_BITS)-1:0]       pending_chars
);

  localparam int DEPTH = 2 ** FIFO_WIDTH_POWER_OF_2;
  localparam int NSLOT = 2 ** CC_ID_BITS;
  localparam int AW    = FIFO_WIDTH_POWER_OF_2;
  localparam int CW    = FIFO_WIDTH_POWER_OF_2 + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [PC_WIDTH-1:0]   pc_mem [DEPTH];
  logic [CC_ID_BITS-1:0] cc_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    cnt_q [NSLOT];

  logic             push;
  logic             pop;
  logic [NSLOT-1:0] inc;
  logic [NSLOT-1:0] dec;

  assign in_ready  = rst & (occ_q != FULL_CNT);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // First-word fall-through: the head entry is visible without a read strobe.
  assign out_pc    = pc_mem[rd_ptr];
  assign out_cc_id = cc_mem[rd_ptr];
  assign occupancy = occ_q;

  always_comb begin
    inc           = '0;
    dec           = '0;
    pending_chars = '0;
    for (int i = 0; i < NSLOT; i++) begin
      inc[i]           = push && (in_cc_id == CC_ID_BITS'(i));
      dec[i]           = pop && (out_cc_id == CC_ID_BITS'(i));
      pending_chars[i] = (cnt_q[i] != '0);
    end
  end

  // Storage needs no reset; stale contents are never exposed while out_valid is low.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr] <= in_pc;
      cc_mem[wr_ptr] <= in_cc_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        occ_q <= occ_q + CNT_ONE;
      end else if (pop && !push) begin
        occ_q <= occ_q - CNT_ONE;
      end
      // Same-slot push and pop cancel out; different slots both move.
      for (int i = 0; i < NSLOT; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_cc_fifo.sv
// tb/tb_pc_cc_fifo.sv - self-checking bench for pc_cc_fifo against a queue model
// Directed test-plan sequences followed by randomized traffic.
module tb_pc_cc_fifo;

  localparam int PCW   = 9;
  localparam int CCB   = 2;
  localparam int P2    = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [PCW-1:0]  in_pc = '0;
  logic [CCB-1:0]  in_cc_id = '0;
  logic            in_ready;
  logic            out_valid;
  logic [PCW-1:0]  out_pc;
  logic [CCB-1:0]  out_cc_id;
  logic            out_ready = 1'b0;
  logic [P2:0]     occupancy;
  logic [3:0]      pending_chars;

  pc_cc_fifo #(.PC_WIDTH(PCW), .CC_ID_BITS(CCB), .FIFO_WIDTH_POWER_OF_2(P2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_cc_id(in_cc_id), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_cc_id(out_cc_id), .out_ready(out_ready),
    .occupancy(occupancy), .pending_chars(pending_chars)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [CCB-1:0] cc;
  } entry_t;

  entry_t q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int m_pending();
    int p = 0;
    foreach (q[k]) p |= (1 << q[k].cc);
    return p;
  endfunction

  // Model advance using the inputs present at the edge and the model's own state.
  task automatic model_edge();
    bit m_push, m_pop;
    entry_t e;
    m_push = in_valid && rst && (q.size() != DEPTH);
    m_pop  = (q.size() != 0) && out_ready;
    if (!rst || flush) begin
      q.delete();
    end else begin
      if (m_pop) e = q.pop_front();
      if (m_push) q.push_back('{pc: in_pc, cc: in_cc_id});
    end
  endtask

  task automatic cyc(input bit v, input int pc, input int cc, input bit rdy,
                     input bit fl, input bit r);
    in_valid  = v;
    in_pc     = PCW'(pc);
    in_cc_id  = CCB'(cc);
    out_ready = rdy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    model_edge();
    chk_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(rst && (q.size() != DEPTH)));
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("occupancy", int'(occupancy), q.size());
      chk("pending_chars", int'(pending_chars), m_pending());
      if (q.size() != 0) begin
        chk("out_pc", int'(out_pc), int'(q[0].pc));
        chk("out_cc_id", int'(out_cc_id), int'(q[0].cc));
      end
    end
  end

  initial begin
    // Reset held with push requests.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 5, 1, 0, 0, 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
    end
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_pending", int'(pending_chars), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);

    // Fill and drain.
    cyc(1, 10, 0, 0, 0, 1);
    chk("first_visible_pc", int'(out_pc), 10);
    cyc(1, 11, 1, 0, 0, 1);
    cyc(1, 12, 1, 0, 0, 1);
    cyc(1, 13, 3, 0, 0, 1);
    chk("full_occ", int'(occupancy), 4);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_pending", int'(pending_chars), 4'b1011);
    cyc(1, 99, 2, 0, 0, 1);
    chk("fifth_push_occ", int'(occupancy), 4);
    chk("fifth_push_pending", int'(pending_chars), 4'b1011);
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", int'(out_pc), 10 + k);
      cyc(0, 0, 0, 1, 0, 1);
    end
    chk("drain_occ", int'(occupancy), 0);
    chk("drain_pending", int'(pending_chars), 0);

    // Simultaneous push/pop with wrap-around.
    cyc(1, 20, 2, 0, 0, 1);
    cyc(1, 21, 1, 0, 0, 1);
    chk("pp_start_occ", int'(occupancy), 2);
    for (int i = 0; i < 10; i++) begin
      chk("pp_head_pc", int'(out_pc), 20 + i);
      cyc(1, 22 + i, (i == 0) ? 0 : (i == 1) ? 1 : int'($urandom_range(3)), 1, 0, 1);
      chk("pp_occ", int'(occupancy), 2);
      if (i == 0) chk("pp_clear2_set0", int'(pending_chars), 4'b0011);
      if (i == 1) chk("pp_same_id_bit1", int'(pending_chars[1]), 1);
    end

    // Full with pop: pop-only cycle, then push accepted.
    cyc(1, 32, 0, 0, 0, 1);
    cyc(1, 33, 3, 0, 0, 1);
    chk("fp_full_occ", int'(occupancy), 4);
    cyc(1, 40, 2, 1, 0, 1);
    chk("fp_pop_only_occ", int'(occupancy), 3);
    chk("fp_in_ready", int'(in_ready), 1);
    cyc(1, 41, 2, 0, 0, 1);
    chk("fp_push_occ", int'(occupancy), 4);

    // Flush beats push and pop.
    cyc(0, 0, 0, 1, 0, 1);
    chk("fl_pre_occ", int'(occupancy), 3);
    cyc(1, 77, 1, 1, 1, 1);
    chk("fl_occ", int'(occupancy), 0);
    chk("fl_out_valid", int'(out_valid), 0);
    chk("fl_pending", int'(pending_chars), 0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    chk("fl_never_out", int'(out_valid), 0);

    // Stall stability.
    cyc(1, 50, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 51 + i, 2, 0, 0, 1);
      chk("stall_pc", int'(out_pc), 50);
      chk("stall_cc", int'(out_cc_id), 1);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(3) != 0, $urandom_range(511), $urandom_range(3),
          $urandom_range(2) != 0, $urandom_range(40) == 0, $urandom_range(80) != 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_cc_fifo.md
# pc_cc_fifo

Thread buffer between a regex CPU's continuation output (`output_pc`/`output_cc_id`) and the instruction-pc input (`input_pc`/`input_cc_id`) of the same or another CPU. It stores pending (pc, cc_id) threads in a circular FIFO with ready/valid on both sides. It also tracks per-character occupancy, so the window controller knows which character slots still have queued threads. Its `in_ready` never depends combinationally on `out_ready`, which keeps the CPU-to-FIFO-to-CPU feedback loop free of combinational paths.

## Interface
- `PC_WIDTH`, 9, pc width.
- `CC_ID_BITS`, 2, character-slot id width; window holds 2**CC_ID_BITS slots.
- `FIFO_WIDTH_POWER_OF_2`, 2, log2 of depth; DEPTH = 2**FIFO_WIDTH_POWER_OF_2.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-low (asserted when 0, sampled on `clk` rising edge).
- `flush`  in  1  synchronous clear of all queued threads.
- `in_valid`  in  1  push request.
- `in_pc`  in  PC_WIDTH  pushed pc.
- `in_cc_id`  in  CC_ID_BITS  pushed slot id.
- `in_ready`  out  1  space available.
- `out_valid`  out  1  head entry valid.
- `out_pc`  out  PC_WIDTH  head pc.
- `out_cc_id`  out  CC_ID_BITS  head slot id.
- `out_ready`  in  1  consumer takes head.
- `occupancy`  out  FIFO_WIDTH_POWER_OF_2+1  number of stored entries, 0..DEPTH.
- `pending_chars`  out  2**CC_ID_BITS  bit i = 1 iff at least one stored entry has cc_id i.

## Operation
- **Storage:** DEPTH x (PC_WIDTH+CC_ID_BITS) register array. Write pointer and read pointer are FIFO_WIDTH_POWER_OF_2 bits wide and wrap modulo DEPTH. `occupancy` is a separate counter.
- **Push and pop:**
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
  - `in_ready` = `rst` & (`occupancy` != DEPTH). It never uses `out_ready`.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- **Head output:** `out_valid` = (`occupancy` != 0). `out_pc`/`out_cc_id` read array[rd_ptr] combinationally (first-word fall-through). Head data is stable while `out_valid & ~out_ready`.
- **Occupancy counter:** push only: +1. Pop only: −1. Both in one cycle: unchanged, and both pointers advance.
- **Per-slot counters:** one counter per slot, FIFO_WIDTH_POWER_OF_2+1 bits each.
  - Push increments `cnt[in_cc_id]`.
  - Pop decrements `cnt[out_cc_id]`.
  - Push and pop to the same id in one cycle leave it unchanged; to different ids, both update.
  - `pending_chars[i]` = (`cnt[i]` != 0), registered-derived.
  - Invariant: the sum of `cnt` equals `occupancy`.
- **Flush:**
  - `flush`=1 in the cycle resets both pointers, `occupancy` and all `cnt` to 0 at the next edge.
  - A push or pop in the flush cycle is discarded; flush has priority over both.
  - `in_ready` and `out_valid` in the flush cycle still follow current state.
- **Reset (`rst`=0):** pointers, `occupancy` and all `cnt` go to 0. Array contents are don't-care.
  - During reset: `in_ready`=0, `out_valid`=0, `occupancy`=0, `pending_chars`=0.
  - `out_pc`/`out_cc_id` are don't-care while `out_valid`=0.
  - Reset mid-operation discards all entries. The first cycle after reset release shows `in_ready`=1, `out_valid`=0.
- **Ordering:** strict FIFO; entries leave in push order regardless of cc_id.

## Timing
- Push-to-visible latency: 1 cycle. An entry pushed at edge N gives `out_valid`=1 with its data in cycle N+1, when the FIFO was empty.
- `occupancy` and `pending_chars` update at the same edge as the push or pop.
- Throughput: one push and one pop per cycle when 0 < `occupancy` < DEPTH. When full, at most one pop per cycle; a push becomes possible the cycle after a pop.
- Combinational paths:
  - `out_*` depend only on registers.
  - `in_ready` depends only on registers and `rst`.
  - No input-to-output combinational path.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles while driving `in_valid`=1 -> `in_ready`=0, `out_valid`=0, `occupancy`=0, `pending_chars`=0. After release: `in_ready`=1, nothing stored.
- **Fill and drain (DEPTH=4):** push (10,0),(11,1),(12,1),(13,3) with `out_ready`=0.
  - After the 4th push: `occupancy`=4, `in_ready`=0, `pending_chars`=4'b1011.
  - A 5th push attempt is not stored.
  - Drain: outputs 10,11,12,13 in order, ending with `occupancy`=0, `pending_chars`=0.
- **Simultaneous push/pop and wrap-around:** at `occupancy`=2, push and pop every cycle for 10 cycles with incrementing pc -> `occupancy` stays 2, pointers wrap, output order preserved.
  - Same-id push/pop keeps that `pending_chars` bit set.
  - Popping the last id-2 entry while pushing id-0 clears bit 2 and sets bit 0 at the same edge.
- **Full with pop:** at `occupancy`=4, `out_ready`=1 and `in_valid`=1.
  - Cycle 1: pop only; `occupancy`=3.
  - Cycle 2: `in_ready`=1, the push is accepted.
- **Flush:** at `occupancy`=3, assert `flush` together with push and pop -> next cycle `occupancy`=0, `out_valid`=0, `pending_chars`=0; the pushed entry is never output.
- **Stall stability:** with `out_valid`=1 and `out_ready`=0 for 5 cycles while pushes continue -> `out_pc`/`out_cc_id` remain constant.
